// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : operand_loader
// Description : Front-end stage for the lab3 ALU on the DE1 board.
//               Synchronises and edge-detects the enter/run strobes.
//               Shifts switch nibbles into the 32-bit operands busA/busB and
//               latches the 3-bit ALU control.
//               Sequences one ALU evaluation and registers the result and
//               z/v/c/n flags for the seg7 display path.
// Ports       : clk, reset (sync, active-high)
//               enter, run           strobe levels, asynchronous to clk
//               sw_data, sw_ctrl     nibble and ALU control from the switches
//               sw_sel               00 busA, 01 busB, 10 control, 11 clear
//               alu_out, alu_flags   ALU result and {z,v,c,n}
//               busA, busB, control  operands and control driven to the ALU
//               alu_start            one-cycle pulse when evaluation starts
//               result, flags        registered ALU result and flags
//               result_valid         high while result/flags are current
//               busy                 high while an evaluation is in flight
//               a_full, b_full       NIBBLES nibbles loaded since last clear
// Revision    : 1.0 - initial release
// ============================================================================
module operand_loader #(
    parameter int ALU_LAT = 2,
    parameter int NIBBLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enter,
    input  logic        run,
    input  logic [3:0]  sw_data,
    input  logic [2:0]  sw_ctrl,
    input  logic [1:0]  sw_sel,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic [31:0] busA,
    output logic [31:0] busB,
    output logic [2:0]  control,
    output logic        alu_start,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        result_valid,
    output logic        busy,
    output logic        a_full,
    output logic        b_full
);

    localparam int LAT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam int CNT_W = $clog2(NIBBLES + 1);

    localparam logic [LAT_W-1:0] c_lat_init = LAT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] c_nib_full = CNT_W'(NIBBLES);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_exec = 1'b1;

    // Two synchroniser flops per strobe plus a third for edge detection.
    logic r_enter_s1, r_enter_s2, r_enter_s3;
    logic r_run_s1,   r_run_s2,   r_run_s3;
    logic w_enter_evt, w_run_evt;

    logic [0:0]       r_state;
    logic [LAT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
    logic [31:0]      r_bus_a, r_bus_b, r_result;
    logic [2:0]       r_control;
    logic [3:0]       r_flags;
    logic             r_alu_start, r_result_valid, r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enter_s1 <= 1'b0;
            r_enter_s2 <= 1'b0;
            r_enter_s3 <= 1'b0;
            r_run_s1   <= 1'b0;
            r_run_s2   <= 1'b0;
            r_run_s3   <= 1'b0;
        end else begin
            r_enter_s1 <= enter;
            r_enter_s2 <= r_enter_s1;
            r_enter_s3 <= r_enter_s2;
            r_run_s1   <= run;
            r_run_s2   <= r_run_s1;
            r_run_s3   <= r_run_s2;
        end
    end

    // Rising edge only: a held key yields a single event.
    assign w_enter_evt = r_enter_s2 & ~r_enter_s3;
    assign w_run_evt   = r_run_s2   & ~r_run_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_lat          <= '0;
            r_cnt_a        <= '0;
            r_cnt_b        <= '0;
            r_bus_a        <= '0;
            r_bus_b        <= '0;
            r_control      <= '0;
            r_result       <= '0;
            r_flags        <= '0;
            r_alu_start    <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // enter has priority; a coincident run event is dropped.
                    if (w_enter_evt) begin
                        case (sw_sel)
                            2'b00: begin
                                // Keeps shifting once full; oldest nibble drops off.
                                r_bus_a        <= {r_bus_a[27:0], sw_data};
                                r_result_valid <= 1'b0;
                                if (r_cnt_a != c_nib_full) begin
                                    r_cnt_a <= r_cnt_a + c_cnt_one;
                                end
                            end
                            2'b01: begin
                                r_bus_b        <= {r_bus_b[27:0], sw_data};
                                r_result_valid <= 1'b0;
                                if (r_cnt_b != c_nib_full) begin
                                    r_cnt_b <= r_cnt_b + c_cnt_one;
                                end
                            end
                            2'b10: begin
                                r_control      <= sw_ctrl;
                                r_result_valid <= 1'b0;
                            end
                            default: begin
                                // Clear-all leaves control untouched.
                                r_bus_a        <= '0;
                                r_bus_b        <= '0;
                                r_cnt_a        <= '0;
                                r_cnt_b        <= '0;
                                r_result       <= '0;
                                r_flags        <= '0;
                                r_result_valid <= 1'b0;
                            end
                        endcase
                    end else if (w_run_evt) begin
                        r_state     <= c_st_exec;
                        r_alu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_lat       <= c_lat_init;
                    end
                end
                c_st_exec: begin
                    // Strobe events are ignored here; operands stay frozen.
                    if (r_lat == '0) begin
                        r_result       <= alu_out;
                        r_flags        <= alu_flags;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= c_st_idle;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busA         = r_bus_a;
    assign busB         = r_bus_b;
    assign control      = r_control;
    assign alu_start    = r_alu_start;
    assign result       = r_result;
    assign flags        = r_flags;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign a_full       = (r_cnt_a == c_nib_full);
    assign b_full       = (r_cnt_b == c_nib_full);

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_loader
// Description : Directed self-checking bench for operand_loader with
//               hand-computed expected values (ALU_LAT=2, NIBBLES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enter;
    logic        run;
    logic [3:0]  sw_data;
    logic [2:0]  sw_ctrl;
    logic [1:0]  sw_sel;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;
    logic [31:0] busA, busB, result;
    logic [2:0]  control;
    logic [3:0]  flags;
    logic        alu_start, result_valid, busy, a_full, b_full;

    int n_cmp = 0;
    int n_err = 0;
    logic saw_busy;

    operand_loader #(
        .ALU_LAT (2),
        .NIBBLES (8)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enter        (enter),
        .run          (run),
        .sw_data      (sw_data),
        .sw_ctrl      (sw_ctrl),
        .sw_sel       (sw_sel),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .busA         (busA),
        .busB         (busB),
        .control      (control),
        .alu_start    (alu_start),
        .result       (result),
        .flags        (flags),
        .result_valid (result_valid),
        .busy         (busy),
        .a_full       (a_full),
        .b_full       (b_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One enter press held for several cycles, then released.
    task automatic press(input logic [1:0] sel, input logic [3:0] d, input logic [2:0] c);
        @(posedge clk);
        #1;
        sw_sel  = sel;
        sw_data = d;
        sw_ctrl = c;
        enter   = 1'b1;
        repeat (5) @(posedge clk);
        #1 enter = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        enter     = 1'b0;
        run       = 1'b0;
        sw_data   = '0;
        sw_ctrl   = '0;
        sw_sel    = '0;
        alu_out   = '0;
        alu_flags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busA",  busA, 32'h0);
        check("rst_busB",  busB, 32'h0);
        check("rst_ctrl",  {29'h0, control}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_status", {26'h0, alu_start, result_valid, busy, a_full, b_full, flags == 4'h0},
              32'h1);
        reset = 1'b0;

        // 1. Eight nibbles into busA.
        for (int i = 1; i <= 7; i++) press(2'b00, 4'(i), 3'b000);
        @(negedge clk);
        check("a_full_at7", {31'h0, a_full}, 32'h0);
        press(2'b00, 4'h8, 3'b000);
        @(negedge clk);
        check("busA_8", busA, 32'h12345678);
        check("a_full_8", {31'h0, a_full}, 32'h1);
        check("busB_untouched", busB, 32'h0);

        // 2. Ninth nibble shifts out the oldest.
        press(2'b00, 4'h9, 3'b000);
        @(negedge clk);
        check("busA_9", busA, 32'h23456789);
        check("a_full_9", {31'h0, a_full}, 32'h1);

        // 3. Control load, then an evaluation.
        press(2'b10, 4'h0, 3'b010);
        @(negedge clk);
        check("control", {29'h0, control}, 32'h2);
        check("start_idle", {31'h0, alu_start}, 32'h0);
        alu_out   = 32'hDEAD_BEEF;
        alu_flags = 4'b0010;
        @(posedge clk);
        #1 run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("start_pulse", {30'h0, alu_start, busy}, 32'h3);
        run = 1'b0;
        @(negedge clk);
        check("start_drop", {29'h0, alu_start, busy, result_valid}, 32'h2);
        @(negedge clk);
        check("not_yet_valid", {31'h0, result_valid}, 32'h0);
        @(negedge clk);
        check("result", result, 32'hDEAD_BEEF);
        check("flags", {28'h0, flags}, 32'h2);
        check("valid_done", {30'h0, result_valid, busy}, 32'h2);
        check("busA_stable", busA, 32'h23456789);

        // 4. Held enter loads once; enter during EXEC is dropped.
        @(posedge clk);
        #1;
        sw_sel  = 2'b01;
        sw_data = 4'hA;
        enter   = 1'b1;
        repeat (50) @(posedge clk);
        #1 enter = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_once", busB, 32'h0000000A);
        check("load_clr_valid", {31'h0, result_valid}, 32'h0);
        alu_out   = 32'h0000_1234;
        alu_flags = 4'b1000;
        sw_sel    = 2'b00;
        sw_data   = 4'hF;
        @(posedge clk);
        #1 run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("exec_start2", {31'h0, busy}, 32'h1);
        run   = 1'b0;
        enter = 1'b1;
        repeat (8) @(posedge clk);
        #1 enter = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("exec_drop_enter", busA, 32'h23456789);
        check("result2", result, 32'h0000_1234);
        check("flags2_valid", {27'h0, flags, result_valid}, 32'h11);

        // 5. Simultaneous enter and run: load wins, no evaluation.
        @(posedge clk);
        #1;
        sw_sel   = 2'b01;
        sw_data  = 4'h5;
        enter    = 1'b1;
        run      = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        enter = 1'b0;
        run   = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("both_busy", {31'h0, saw_busy}, 32'h0);
        check("both_load", busB, 32'h000000A5);
        check("both_valid", {31'h0, result_valid}, 32'h0);
        press(2'b11, 4'h0, 3'b000);
        @(negedge clk);
        check("clr_busA", busA, 32'h0);
        check("clr_busB", busB, 32'h0);
        check("clr_result", result, 32'h0);
        check("clr_flags_full", {26'h0, flags, a_full, b_full}, 32'h0);
        check("clr_keeps_ctrl", {29'h0, control}, 32'h2);

        // 6. Reset one cycle into EXEC aborts the evaluation.
        alu_out   = 32'hCAFE_F00D;
        alu_flags = 4'b1111;
        @(posedge clk);
        #1 run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_in_exec", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_state", {30'h0, busy, result_valid}, 32'h0);
        check("abort_result", result, 32'h0);
        repeat (5) @(negedge clk);
        check("abort_no_sample", {27'h0, flags, result_valid}, 32'h0);
        check("abort_result_late", result, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
